// File: rtl/evt_frame_gen.sv
// rtl/evt_frame_gen.sv - event-frame transmitter: header, pattern data, footer, idle gap
module evt_frame_gen #(
    parameter int N_DATA  = 1024,
    parameter int GROUP   = 16,
    parameter int GAP_MIN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        inject_err,
    input  logic [4:0]  icrate,
    input  logic [4:0]  islot,
    input  logic [9:0]  ispill,
    input  logic [15:0] ievt,
    input  logic [28:0] timestamp,
    input  logic [15:0] cbit,
    input  logic [13:0] seed,
    output logic [15:0] odata,
    output logic        busy,
    output logic        done,
    output logic [31:0] cnt_frame
);

    // One spare bit beyond clog2 so N_DATA itself is representable
    localparam int WW = $clog2(N_DATA) + 1;
    localparam int GW = (GROUP > 1) ? $clog2(GROUP) : 1;

    localparam logic [WW-1:0] HDR_LAST  = WW'(5);
    localparam logic [WW-1:0] DATA_LAST = WW'(N_DATA - 1);
    localparam logic [WW-1:0] ERR_IDX   = WW'(N_DATA / 2);
    localparam logic [WW-1:0] GAP_LAST  = WW'(GAP_MIN - 1);
    localparam logic [GW-1:0] GRP_LAST  = GW'(GROUP - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_FTR  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]    state;
    logic [WW-1:0] wcnt;
    logic [GW-1:0] grp;
    logic [13:0]   pay;
    logic          inj_q;
    logic [4:0]    crate_q;
    logic [4:0]    slot_q;
    logic [9:0]    spill_q;
    logic [15:0]   evt_q;
    logic [28:0]   ts_q;
    logic [15:0]   cbit_q;

    logic [15:0]   hdr_word;
    logic [13:0]   err_mask;

    // Header word selected by position within the header, built from latched fields
    always_comb begin
        hdr_word = 16'h0000;
        case (wcnt[2:0])
            3'd0:    hdr_word = {2'b11, spill_q[3:0], slot_q, crate_q};
            3'd1:    hdr_word = {2'b11, evt_q[7:0], spill_q[9:4]};
            3'd2:    hdr_word = {2'b11, ts_q[5:0], evt_q[15:8]};
            3'd3:    hdr_word = {2'b11, ts_q[19:6]};
            3'd4:    hdr_word = {2'b11, cbit_q[4:0], ts_q[28:20]};
            3'd5:    hdr_word = {2'b11, 3'b000, cbit_q[15:5]};
            default: hdr_word = 16'h0000;
        endcase
    end

    // Single-bit corruption of the middle data word when requested
    always_comb begin
        err_mask = 14'h0000;
        if (inj_q && (wcnt == ERR_IDX))
            err_mask = 14'h0001;
    end

    // Frame sequencer; every output is registered so inputs never reach odata combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            grp       <= '0;
            pay       <= 14'h0000;
            inj_q     <= 1'b0;
            crate_q   <= 5'h00;
            slot_q    <= 5'h00;
            spill_q   <= 10'h000;
            evt_q     <= 16'h0000;
            ts_q      <= 29'h0;
            cbit_q    <= 16'h0000;
            odata     <= 16'h0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt_frame <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    odata <= 16'h0000;
                    busy  <= 1'b0;
                    if (start) begin
                        crate_q <= icrate;
                        slot_q  <= islot;
                        spill_q <= ispill;
                        evt_q   <= ievt;
                        ts_q    <= timestamp;
                        cbit_q  <= cbit;
                        inj_q   <= inject_err;
                        pay     <= seed;
                        grp     <= '0;
                        wcnt    <= '0;
                        state   <= S_HDR;
                    end
                end
                S_HDR: begin
                    odata <= hdr_word;
                    busy  <= 1'b1;
                    if (wcnt == HDR_LAST) begin
                        wcnt  <= '0;
                        state <= S_DATA;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_DATA: begin
                    odata <= {2'b10, pay ^ err_mask};
                    if (grp == GRP_LAST) begin
                        grp <= '0;
                        pay <= pay + 14'h0001;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                    if (wcnt == DATA_LAST) begin
                        wcnt  <= '0;
                        state <= S_FTR;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_FTR: begin
                    odata     <= {2'b01, evt_q[13:0]};
                    done      <= 1'b1;
                    cnt_frame <= cnt_frame + 32'h1;
                    wcnt      <= '0;
                    state     <= S_GAP;
                end
                S_GAP: begin
                    odata <= 16'h0000;
                    if (wcnt == GAP_LAST) begin
                        wcnt  <= '0;
                        state <= S_IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: begin
                    odata <= 16'h0000;
                    busy  <= 1'b0;
                    wcnt  <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evt_frame_gen.sv
// tb/tb_evt_frame_gen.sv - scoreboard bench for evt_frame_gen with a frame-level reference model
module tb_evt_frame_gen;

    localparam int N_DATA  = 1024;
    localparam int GROUP   = 16;
    localparam int GAP_MIN = 4;
    localparam int P       = 6 + N_DATA + 1 + GAP_MIN + 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic        inject_err;
    logic [4:0]  icrate;
    logic [4:0]  islot;
    logic [9:0]  ispill;
    logic [15:0] ievt;
    logic [28:0] timestamp;
    logic [15:0] cbit;
    logic [13:0] seed;
    logic [15:0] odata;
    logic        busy;
    logic        done;
    logic [31:0] cnt_frame;

    evt_frame_gen #(.N_DATA(N_DATA), .GROUP(GROUP), .GAP_MIN(GAP_MIN)) dut (
        .clk(clk), .rst(rst), .start(start), .inject_err(inject_err),
        .icrate(icrate), .islot(islot), .ispill(ispill), .ievt(ievt),
        .timestamp(timestamp), .cbit(cbit), .seed(seed),
        .odata(odata), .busy(busy), .done(done), .cnt_frame(cnt_frame)
    );

    typedef struct {
        logic [15:0] w;
        int          c;
        bit          ftr;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors    = 0;
    int   checks    = 0;
    int   model_cnt = 0;
    int   busy_lo   = 0;
    int   busy_hi   = -1;
    int   cyc       = 0;
    logic rst_q     = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected words of one whole frame accepted at cycle c; word i appears at cycle c+1+i
    task automatic push_frame(input int c);
        logic [15:0] h[6];
        logic [13:0] v;
        exp_t        x;
        h[0] = {2'b11, ispill[3:0], islot, icrate};
        h[1] = {2'b11, ievt[7:0], ispill[9:4]};
        h[2] = {2'b11, timestamp[5:0], ievt[15:8]};
        h[3] = {2'b11, timestamp[19:6]};
        h[4] = {2'b11, cbit[4:0], timestamp[28:20]};
        h[5] = {2'b11, 3'b000, cbit[15:5]};
        for (int i = 0; i < 6; i++) begin
            x.w = h[i]; x.c = c + 1 + i; x.ftr = 1'b0;
            q.push_back(x);
        end
        for (int k = 0; k < N_DATA; k++) begin
            v = 14'((int'(seed) + k / GROUP) % 16384);
            if (inject_err && k == N_DATA / 2)
                v = v ^ 14'h0001;
            x.w = {2'b10, v}; x.c = c + 7 + k; x.ftr = 1'b0;
            q.push_back(x);
        end
        x.w = {2'b01, ievt[13:0]}; x.c = c + 7 + N_DATA; x.ftr = 1'b1;
        q.push_back(x);
        busy_lo = c + 1;
        busy_hi = c + P - 1;
    endtask

    task automatic rand_fields(input logic inj);
        icrate     = 5'($urandom);
        islot      = 5'($urandom);
        ispill     = 10'($urandom);
        ievt       = 16'($urandom);
        timestamp  = 29'($urandom);
        cbit       = 16'($urandom);
        seed       = 14'($urandom);
        inject_err = inj;
    endtask

    // Launch one frame from IDLE, scramble inputs and poke start mid-frame, then wait out the frame
    task automatic run_frame();
        int c;
        start = 1'b1;
        tick();
        c = cyc;
        push_frame(c);
        start = 1'b0;
        rand_fields(1'($urandom));
        for (int i = 0; i < P - 1; i++) begin
            start = (i == 200 || i == 201) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
    endtask

    // Scoreboard monitor: pops the expected word whenever the link carries a non-idle word
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_q) begin
                q.delete();
                model_cnt = 0;
                chk("rst_odata", 32'(odata), 32'h0);
                chk("rst_busy", 32'(busy), 32'h0);
                chk("rst_done", 32'(done), 32'h0);
                chk("rst_cnt_frame", cnt_frame, 32'h0);
            end else begin
                chk("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
                if (odata != 16'h0000) begin
                    if (q.size() == 0) begin
                        chk("unexpected_word", 32'(odata), 32'h0);
                    end else begin
                        e = q.pop_front();
                        chk("word", 32'(odata), 32'(e.w));
                        chk("word_cycle", cyc, e.c);
                        chk("done", 32'(done), 32'(e.ftr));
                        if (e.ftr)
                            model_cnt = model_cnt + 1;
                    end
                end else begin
                    chk("idle_done", 32'(done), 32'h0);
                    if (q.size() > 0 && q[0].c <= cyc) begin
                        chk("missing_word", 32'(odata), 32'(q[0].w));
                        void'(q.pop_front());
                    end
                end
                chk("cnt_frame", cnt_frame, model_cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b1; start = 1'b0;
        icrate = '0; islot = '0; ispill = '0; ievt = '0;
        timestamp = '0; cbit = '0; seed = '0; inject_err = 1'b0;
        repeat (3) tick();

        // Directed reference frame, start in the first cycle after reset
        rst = 1'b0;
        icrate = 5'h03; islot = 5'h0A; ispill = 10'h2F5; ievt = 16'hBEEF;
        timestamp = 29'h1ABCDEF0; cbit = 16'h8421; seed = 14'h0000; inject_err = 1'b0;
        run_frame();

        // Payload wrap across 3FFF -> 0000
        rand_fields(1'b0);
        seed = 14'h3FFE;
        run_frame();

        // Error injection on the middle data word
        rand_fields(1'b1);
        seed = 14'h0000;
        run_frame();

        // start held high: three back-to-back frames, fields change mid-frame
        rand_fields(1'b0);
        start = 1'b1;
        tick();
        c = cyc;
        push_frame(c);
        for (int f = 1; f < 3; f++) begin
            for (int i = 0; i < P - 1; i++) begin
                if (i == 300)
                    rand_fields(1'($urandom));
                tick();
            end
            tick();
            c = cyc;
            push_frame(c);
        end
        start = 1'b0;
        repeat (P - 1) tick();

        // Reset while data word 300 is on the link
        rand_fields(1'b0);
        start = 1'b1;
        tick();
        c = cyc;
        push_frame(c);
        start = 1'b0;
        while (cyc < c + 7 + 300) tick();
        rst = 1'b1;
        tick();
        busy_lo = 0;
        busy_hi = -1;
        rst = 1'b0;
        rand_fields(1'b0);
        run_frame();

        // Randomized frames with random idle spacing
        for (int n = 0; n < 4; n++) begin
            rand_fields(1'($urandom));
            repeat ($urandom_range(0, 5)) tick();
            run_frame();
        end

        repeat (4) tick();
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
